// File: rtl/clk_div_pkg.sv
// clk_div_pkg
// Shared constants for the multi-channel clock divider.
//   CNT_W_DEF / NCH_DEF : default counter width and channel count
//   DIV_MIN             : smallest usable terminal count (a zero request maps to this)
//   DIV_RST / HIGH_RST  : reset values of divider and high-phase registers (div-by-2, 50%)
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF = 5;
    localparam int unsigned NCH_DEF   = 4;
    localparam int unsigned DIV_MIN   = 1;
    localparam int unsigned DIV_RST   = 1;
    localparam int unsigned HIGH_RST  = 1;

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan
// One divider channel: period counter, shadow/active configuration and registered outputs.
// Ports:
//   i_clk_in     : system clock
//   i_rst_n      : asynchronous active-low reset
//   i_enable     : run enable (level)
//   i_div_base   : requested terminal count (0 treated as DIV_MIN)
//   i_high_cnt   : requested high-phase length in clock cycles
//   i_cfg_load   : strobe capturing i_div_base / i_high_cnt
//   i_sync       : strobe restarting the counter in phase with other channels
//   o_clk_out    : divided clock
//   o_tick       : one-cycle pulse at each period start
//   o_cfg_pend   : captured configuration waiting for a period boundary
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             i_clk_in,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_div_base,
    input  logic [CNT_W-1:0] i_high_cnt,
    input  logic             i_cfg_load,
    input  logic             i_sync,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_cfg_pend
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_a;
    logic [CNT_W-1:0] r_high_a;
    logic [CNT_W-1:0] r_div_s;
    logic [CNT_W-1:0] r_high_s;
    logic             r_pend;
    logic             r_clk_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_div_in;
    logic             w_wrap;
    logic             w_boundary;

    assign w_div_in = (i_div_base == '0) ? CNT_W'(DIV_MIN) : i_div_base;
    assign w_wrap   = i_enable && (r_cnt == r_div_a);
    // A disabled channel sits at cnt=0 permanently, so every idle edge is a period boundary.
    assign w_boundary = !i_enable || i_sync || w_wrap;

    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_pend    <= 1'b0;
            r_div_a   <= CNT_W'(DIV_RST);
            r_high_a  <= CNT_W'(HIGH_RST);
            r_div_s   <= CNT_W'(DIV_RST);
            r_high_s  <= CNT_W'(HIGH_RST);
        end else begin
            r_cnt     <= w_boundary ? '0 : r_cnt + CNT_W'(1);
            r_clk_out <= i_enable && (r_cnt < r_high_a);
            r_tick    <= i_enable && (r_cnt == '0);

            if (i_cfg_load) begin
                r_div_s  <= w_div_in;
                r_high_s <= i_high_cnt;
            end

            // A load landing on a boundary bypasses the shadow stage entirely.
            if (i_cfg_load && w_boundary) begin
                r_div_a  <= w_div_in;
                r_high_a <= i_high_cnt;
                r_pend   <= 1'b0;
            end else if (i_cfg_load) begin
                r_pend   <= 1'b1;
            end else if (r_pend && w_boundary) begin
                r_div_a  <= r_div_s;
                r_high_a <= r_high_s;
                r_pend   <= 1'b0;
            end
        end
    end

    assign o_clk_out  = r_clk_out;
    assign o_tick     = r_tick;
    assign o_cfg_pend = r_pend;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi
// NCH independent programmable clock dividers sharing one clock and a common sync strobe.
// Ports:
//   i_clk_in    : system clock
//   i_rst_n     : asynchronous active-low reset
//   i_enable    : per-channel run enable
//   i_div_base  : packed per-channel terminal counts, channel k at [k*CNT_W +: CNT_W]
//   i_high_cnt  : packed per-channel high-phase lengths, same packing
//   i_cfg_load  : per-channel configuration capture strobe
//   i_sync      : restarts all enabled channels in phase
//   o_clk_out   : per-channel divided clocks
//   o_tick      : per-channel period-start pulses
//   o_cfg_pend  : per-channel pending-configuration flags
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 i_clk_in,
    input  logic                 i_rst_n,
    input  logic [NCH-1:0]       i_enable,
    input  logic [NCH*CNT_W-1:0] i_div_base,
    input  logic [NCH*CNT_W-1:0] i_high_cnt,
    input  logic [NCH-1:0]       i_cfg_load,
    input  logic                 i_sync,
    output logic [NCH-1:0]       o_clk_out,
    output logic [NCH-1:0]       o_tick,
    output logic [NCH-1:0]       o_cfg_pend
);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .i_clk_in   (i_clk_in),
            .i_rst_n    (i_rst_n),
            .i_enable   (i_enable[g]),
            .i_div_base (i_div_base[g*CNT_W +: CNT_W]),
            .i_high_cnt (i_high_cnt[g*CNT_W +: CNT_W]),
            .i_cfg_load (i_cfg_load[g]),
            .i_sync     (i_sync),
            .o_clk_out  (o_clk_out[g]),
            .o_tick     (o_tick[g]),
            .o_cfg_pend (o_cfg_pend[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi
// Self-checking bench: directed scenarios plus randomized traffic, all cycles compared against
// a timestamp-based reference model (phase = edges since period origin, modulo period).
module tb_clk_div_multi;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 5;

    logic                 clk_in = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       enable;
    logic [NCH*CNT_W-1:0] div_base;
    logic [NCH*CNT_W-1:0] high_cnt;
    logic [NCH-1:0]       cfg_load;
    logic                 sync;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       cfg_pend;

    clk_div_multi #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) u_dut (
        .i_clk_in   (clk_in),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_div_base (div_base),
        .i_high_cnt (high_cnt),
        .i_cfg_load (cfg_load),
        .i_sync     (sync),
        .o_clk_out  (clk_out),
        .o_tick     (tick),
        .o_cfg_pend (cfg_pend)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_div    [NCH];
    int m_high   [NCH];
    int m_div_s  [NCH];
    int m_high_s [NCH];
    int m_pend   [NCH];
    int m_origin [NCH];
    int n_edge;
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_pend;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_div[k]    = 1;
            m_high[k]   = 1;
            m_div_s[k]  = 1;
            m_high_s[k] = 1;
            m_pend[k]   = 0;
            m_origin[k] = n_edge;
        end
        exp_clk  = '0;
        exp_tick = '0;
        exp_pend = '0;
    endfunction

    // One rising edge of the model, using the inputs currently driven.
    function automatic void model_edge();
        for (int k = 0; k < NCH; k++) begin
            int p;
            int b;
            int h;
            bit bnd;
            p = (n_edge - m_origin[k]) % (m_div[k] + 1);
            exp_tick[k] = enable[k] && (p == 0);
            exp_clk[k]  = enable[k] && (p < m_high[k]);
            bnd = !enable[k] || sync || (p == m_div[k]);
            b = int'(div_base[k*CNT_W +: CNT_W]);
            h = int'(high_cnt[k*CNT_W +: CNT_W]);
            if (b == 0) b = 1;
            if (cfg_load[k]) begin
                m_div_s[k]  = b;
                m_high_s[k] = h;
                if (bnd) begin
                    m_div[k]  = b;
                    m_high[k] = h;
                    m_pend[k] = 0;
                end else begin
                    m_pend[k] = 1;
                end
            end else if (m_pend[k] != 0 && bnd) begin
                m_div[k]  = m_div_s[k];
                m_high[k] = m_high_s[k];
                m_pend[k] = 0;
            end
            if (bnd) m_origin[k] = n_edge + 1;
            exp_pend[k] = (m_pend[k] != 0);
        end
        n_edge++;
    endfunction

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check_eq("clk_out", 32'(clk_out), 32'(exp_clk));
        check_eq("tick", 32'(tick), 32'(exp_tick));
        check_eq("cfg_pend", 32'(cfg_pend), 32'(exp_pend));
        cfg_load = '0;
        sync     = 1'b0;
    endtask

    task automatic set_cfg(input int k, input int d, input int h);
        div_base[k*CNT_W +: CNT_W] = CNT_W'(d);
        high_cnt[k*CNT_W +: CNT_W] = CNT_W'(h);
    endtask

    // Asynchronous reset pulse landing mid-cycle.
    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        check_eq("rst_clk_out", 32'(clk_out), 32'd0);
        check_eq("rst_tick", 32'(tick), 32'd0);
        check_eq("rst_pend", 32'(cfg_pend), 32'd0);
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int k = 0; k < NCH; k++) m_origin[k] = n_edge;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks0;
        int highs0;
        int ticks1;
        int highs1;
        int waited;

        rst_n    = 1'b0;
        enable   = '0;
        cfg_load = '0;
        sync     = 1'b0;
        div_base = '0;
        high_cnt = '0;
        n_edge   = 0;
        model_reset();
        #3;
        check_eq("init_clk_out", 32'(clk_out), 32'd0);
        check_eq("init_tick", 32'(tick), 32'd0);
        check_eq("init_pend", 32'(cfg_pend), 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;

        // Ch0 div=4 high=2, ch1 div=0 high=1; loaded while disabled so they apply at once.
        set_cfg(0, 4, 2);
        set_cfg(1, 0, 1);
        cfg_load = 4'b0011;
        step();
        enable = 4'b0011;
        ticks0 = 0; highs0 = 0; ticks1 = 0; highs1 = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            ticks0 += int'(tick[0]);
            highs0 += int'(clk_out[0]);
            ticks1 += int'(tick[1]);
            highs1 += int'(clk_out[1]);
        end
        check_eq("div4_ticks", 32'(ticks0), 32'd4);
        check_eq("div4_highs", 32'(highs0), 32'd8);
        check_eq("div0_ticks", 32'(ticks1), 32'd10);
        check_eq("div0_highs", 32'(highs1), 32'd10);

        // Ch2 div=9 high=5, reload to div=3 high=1 when cnt=4.
        set_cfg(2, 9, 5);
        cfg_load = 4'b0100;
        step();
        enable[2] = 1'b1;
        repeat (4) step();
        set_cfg(2, 3, 1);
        cfg_load = 4'b0100;
        step();
        check_eq("reload_pend", 32'(cfg_pend[2]), 32'd1);
        waited = 0;
        while (cfg_pend[2] && waited < 20) begin
            step();
            waited++;
        end
        check_eq("reload_wait", 32'(waited), 32'd5);
        ticks0 = 0; highs0 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            ticks0 += int'(tick[2]);
            highs0 += int'(clk_out[2]);
        end
        check_eq("reload_ticks", 32'(ticks0), 32'd2);
        check_eq("reload_highs", 32'(highs0), 32'd2);

        // Ch0 div=2, ch1 div=5 applied on a sync; both tick together afterwards.
        set_cfg(0, 2, 1);
        set_cfg(1, 5, 3);
        cfg_load = 4'b0011;
        step();
        repeat (3) step();
        sync = 1'b1;
        step();
        step();
        check_eq("sync_tick", 32'(tick[1:0]), 32'd3);

        // Reset mid-period with div=6, then divide-by-2 with tick on the first period.
        set_cfg(0, 6, 3);
        cfg_load = 4'b0001;
        step();
        repeat (3) step();
        do_reset();
        step();
        check_eq("post_rst_tick", 32'(tick[0]), 32'd1);
        ticks0 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            ticks0 += int'(tick[0]);
        end
        check_eq("post_rst_ticks", 32'(ticks0), 32'd4);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 19) == 0) enable[k] = ~enable[k];
                if ($urandom_range(0, 7) == 0) begin
                    set_cfg(k, int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
                    cfg_load[k] = 1'b1;
                end
            end
            sync = ($urandom_range(0, 39) == 0);
            if (i == 1500) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 5, counter and configuration width per channel (2..16).
REQ-003 clk_in  input  1  single system clock; every register is clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  NCH  per-channel run enable, level-sensitive.
REQ-006 div_base  input  NCH*CNT_W  per-channel terminal count; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-007 high_cnt  input  NCH*CNT_W  per-channel high-phase length in clk_in cycles, packed the same way as div_base.
REQ-008 cfg_load  input  NCH  one-cycle strobe that captures div_base/high_cnt for channel k into its shadow registers.
REQ-009 sync  input  1  one-cycle strobe that restarts all enabled channels in phase.
REQ-010 clk_out  output  NCH  divided clock per channel, registered.
REQ-011 tick  output  NCH  one-cycle pulse per channel at each period start, registered.
REQ-012 cfg_pend  output  NCH  high while a captured configuration waits for the channel's next period boundary.

Function
REQ-013 Each channel SHALL hold active registers div_a and high_a, plus a counter cnt; period = div_a+1 clk_in cycles.
REQ-014 A div_base value of 0 SHALL be treated as 1, giving a minimum period of 2 cycles.
REQ-015 While enabled, cnt SHALL increment each cycle and wrap to 0 after reaching div_a.
REQ-016 clk_out[k] SHALL be 1 in the cycle after cnt<high_a, and 0 otherwise.
REQ-017 high_a=0 SHALL give a constant-low clk_out; high_a>div_a SHALL give a constant-high clk_out.
REQ-018 tick[k] SHALL be 1 for exactly one cycle, in the cycle after cnt wraps to 0, including the first cycle after enable rises.
REQ-019 cfg_load[k] SHALL set cfg_pend[k] and latch the inputs into the shadow registers; a later cfg_load overwrites the shadow registers (last load wins).
REQ-020 A pending configuration SHALL transfer to div_a/high_a at the next wrap, and cfg_pend SHALL clear on that same edge.
REQ-021 cfg_load asserted on the wrap edge SHALL apply its values directly at that wrap, with cfg_pend remaining 0.
REQ-022 cfg_load while the channel is disabled SHALL apply immediately, with no pending state.
REQ-023 With enable[k]=0, cnt SHALL be held at 0, clk_out[k]=0 and tick[k]=0.
REQ-024 On a 0->1 transition of enable[k], the channel SHALL start counting from cnt=0.
REQ-025 sync SHALL force cnt=0 in every enabled channel on the next edge, taking priority over increment and wrap.
REQ-026 A pending configuration SHALL be applied on a sync edge, because sync counts as a period boundary.
REQ-027 Channels SHALL be fully independent apart from sync.
REQ-028 The outputs SHALL be glitch-free, because they are register outputs only.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear cnt, clk_out, tick and cfg_pend to 0.
REQ-030 rst_n=0 SHALL set div_a and the shadow divider value to 1 and high_a and the shadow high value to 1 (divide-by-2 at 50% duty).
REQ-031 Reset asserted mid-period SHALL abort the period with no trailing pulse; after release, counting SHALL start at cnt=0 on the first edge with enable=1.
REQ-032 Reset release SHALL be assumed synchronous to clk_in by the integrator; the block contains no synchroniser.

Structure
REQ-033 Package clk_div_pkg SHALL hold the defaults for CNT_W and NCH, the constant DIV_MIN=1, and the reset values of the divider and high registers.
REQ-034 Sub-module clk_div_chan SHALL implement one channel (counter, shadow/active registers, output regs); clk_div_multi SHALL instantiate NCH copies via generate and handle bus slicing.

Verification
REQ-035 div=4, high=2, enable=1 -> clk_out has period 5 with 2 cycles high; tick every 5 cycles.
REQ-036 div=0, high=1 -> behaves as div=1: period 2, 50% duty.
REQ-037 Channel running div=9, high=5; cfg_load with div=3, high=1 at cnt=4 -> cfg_pend=1 until wrap, then period 4 with 1 cycle high, cfg_pend=0.
REQ-038 Ch0 div=2, ch1 div=5, both running; pulse sync -> both tick in the same cycle, 2 cycles after the sync edge.
REQ-039 high=0 -> clk_out stays 0; high=7 with div=5 -> clk_out stays 1; tick continues every 6 cycles in both cases.
REQ-040 rst_n pulsed low mid-period with div=6 -> all outputs 0 immediately; after release the channel runs divide-by-2 with tick on its first period.
